piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in/serial-out transmit stage that sits directly downstream of a parallel data register. It accepts a DATA_WIDTH word over a valid/ready handshake and shifts it out one bit at a time, holding each bit for CLK_DIV clock cycles. It qualifies the serial stream with sout_valid and signals word completion with a one-cycle done pulse. It provides the bit sequencing, counting and flow control that a bare shift register lacks.

Parameters:
DATA_WIDTH, 8, word width in bits; legal range 2 or more.
LSB_FIRST, 1, 1 = bit 0 is shifted out first; 0 = bit DATA_WIDTH-1 is shifted out first.
CLK_DIV, 1, clock cycles per serial bit; legal range 1 or more. CLK_DIV = 0 must cause an elaboration error.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
cl  input  1  synchronous clear; aborts any word in progress
din_valid  input  1  din holds a word to send
din  input  DATA_WIDTH  parallel word
din_ready  output  1  block can accept a word this cycle
sout  output  1  serial data bit
sout_valid  output  1  sout carries a payload bit
busy  output  1  a word is being shifted out
done  output  1  one-cycle pulse after the last bit of a word

Behaviour:
- Reset and state:
  - Single clock domain. rst is asynchronous, active-high and forces the FSM to IDLE.
  - All registers are flopped; no combinational path from din or din_valid to any output.
  - Internal registers: shreg[DATA_WIDTH], bit_cnt of width $clog2(DATA_WIDTH), div_cnt of width max(1, $clog2(CLK_DIV)).
- Values during and after rst:
  - shreg = 0, bit_cnt = 0, div_cnt = 0.
  - sout = 0, sout_valid = 0, busy = 0, done = 0.
  - din_ready = 1, decoded from the IDLE state.
- FSM with two states, IDLE and SHIFT.
- IDLE:
  - din_ready = 1, busy = 0, sout_valid = 0, sout = 0.
  - On din_valid && din_ready: shreg <= din, bit_cnt <= 0, div_cnt <= 0, go to SHIFT.
- SHIFT:
  - din_ready = 0, busy = 1, sout_valid = 1.
  - sout = shreg[0] when LSB_FIRST = 1, else shreg[DATA_WIDTH-1].
  - div_cnt increments every cycle.
  - When div_cnt == CLK_DIV-1 and bit_cnt != DATA_WIDTH-1: div_cnt <= 0, bit_cnt++, and shreg shifts by one toward the output end with 0 filled in.
  - When div_cnt == CLK_DIV-1 and bit_cnt == DATA_WIDTH-1: go to IDLE and set done <= 1 for exactly one cycle.
- Latency:
  - A handshake in cycle T puts the first bit on sout in cycle T+1.
  - The word occupies cycles T+1 through T+DATA_WIDTH*CLK_DIV.
  - done is high in cycle T+DATA_WIDTH*CLK_DIV+1, which is also an IDLE cycle with din_ready = 1.
- Back-to-back words: a word may be accepted in the done cycle. The minimum gap between the last bit of one word and the first bit of the next is one cycle with sout_valid = 0.
- din is sampled only at the handshake. Changes to din or din_valid while busy have no effect. din_valid held high while busy is not lost; it is accepted in the next IDLE cycle.
- cl (synchronous) has priority over everything except rst. It forces the rst values on the next edge, drops the current word without a done pulse, and ignores a simultaneous din_valid handshake.
- rst asserted mid-word returns the block to IDLE immediately and asynchronously: sout_valid and busy fall without waiting for a clock edge, and no done pulse is produced.

Test Plan:
- DATA_WIDTH=8, LSB_FIRST=1, CLK_DIV=1; send din=0xA5 at cycle 0 -> sout = 1,0,1,0,0,1,0,1 in cycles 1-8 with sout_valid=1, busy=1, din_ready=0; done=1 only in cycle 9.
- Same configuration with LSB_FIRST=0; send din=0xA5 -> sout = 1,0,1,0,0,1,0,1 (MSB first). Then send 0x01 -> seven 0s followed by a single 1.
- CLK_DIV=3; send din=0x0F with LSB_FIRST=1 -> each bit held exactly 3 cycles: twelve 1s then twelve 0s across cycles 1-24; done in cycle 25.
- Back-to-back: hold din_valid=1 with din=0x3C and then 0xC3 -> second word accepted in the done cycle; exactly one cycle with sout_valid=0 between the two words; both words' bit sequences correct.
- Abort: assert cl in the cycle carrying bit 3 of 0xFF, with din_valid=1 and din=0x00 -> next cycle sout_valid=0, din_ready=1, no done pulse, and the new word is not captured. Repeat with asynchronous rst asserted mid-cycle -> outputs drop before the next clock edge.
- Hold din_valid low for 20 cycles after reset -> din_ready=1, sout_valid=0 and sout=0 throughout.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmit stage: takes a word over valid/ready and shifts it
// out one bit per CLK_DIV cycles, with sout_valid qualification and a done pulse.
module piso_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int LSB_FIRST  = 1,
  parameter int CLK_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cl,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  din_ready,
  output logic                  sout,
  output logic                  sout_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int BIT_W   = $clog2(DATA_WIDTH);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OUT_IDX = (LSB_FIRST != 0) ? 0 : DATA_WIDTH - 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("piso_serializer: CLK_DIV must be 1 or more");
    end
    if (DATA_WIDTH < 2) begin : g_bad_width
      $error("piso_serializer: DATA_WIDTH must be 2 or more");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   shreg, shreg_nxt;
  logic [BIT_W-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DIV_W-1:0]        div_cnt, div_cnt_nxt;
  logic                    done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      div_cnt <= div_cnt_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    div_cnt_nxt = div_cnt;
    done_nxt    = 1'b0;
    if (cl) begin
      // clear wins over any handshake and suppresses done
      state_nxt   = IDLE;
      shreg_nxt   = '0;
      bit_cnt_nxt = '0;
      div_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (din_valid) begin
            state_nxt   = SHIFT;
            shreg_nxt   = din;
            bit_cnt_nxt = '0;
            div_cnt_nxt = '0;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt_nxt = '0;
            if (bit_cnt == BIT_LAST) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              bit_cnt_nxt = bit_cnt + BIT_W'(1);
              shreg_nxt   = (LSB_FIRST != 0) ? {1'b0, shreg[DATA_WIDTH-1:1]}
                                             : {shreg[DATA_WIDTH-2:0], 1'b0};
            end
          end else begin
            div_cnt_nxt = div_cnt + DIV_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so rst drops them asynchronously.
  assign din_ready  = (state == IDLE);
  assign busy       = (state == SHIFT);
  assign sout_valid = busy;
  assign sout       = busy & shreg[OUT_IDX];

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB/MSB-first, divided bit rate, back-to-back,
// clear abort, async reset abort and idle behaviour.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] cl, din_valid, din_ready, sout, sout_valid, busy, done;
  logic [7:0] din [3];
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  // 0: LSB first, div 1   1: MSB first, div 1   2: LSB first, div 3
  piso_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1), .CLK_DIV(1)) u_lsb (
    .clk(clk), .rst(rst), .cl(cl[0]), .din_valid(din_valid[0]), .din(din[0]),
    .din_ready(din_ready[0]), .sout(sout[0]), .sout_valid(sout_valid[0]),
    .busy(busy[0]), .done(done[0]));

  piso_serializer #(.DATA_WIDTH(8), .LSB_FIRST(0), .CLK_DIV(1)) u_msb (
    .clk(clk), .rst(rst), .cl(cl[1]), .din_valid(din_valid[1]), .din(din[1]),
    .din_ready(din_ready[1]), .sout(sout[1]), .sout_valid(sout_valid[1]),
    .busy(busy[1]), .done(done[1]));

  piso_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1), .CLK_DIV(3)) u_div3 (
    .clk(clk), .rst(rst), .cl(cl[2]), .din_valid(din_valid[2]), .din(din[2]),
    .din_ready(din_ready[2]), .sout(sout[2]), .sout_valid(sout_valid[2]),
    .busy(busy[2]), .done(done[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Checks one busy cycle; exp_bit is the hand-derived serial bit.
  task automatic chk_bit(input int idx, input int c, input logic exp_bit);
    chk($sformatf("u%0d c%0d sout", idx, c), sout[idx], exp_bit);
    chk($sformatf("u%0d c%0d sout_valid", idx, c), sout_valid[idx], 1);
    chk($sformatf("u%0d c%0d busy", idx, c), busy[idx], 1);
    chk($sformatf("u%0d c%0d din_ready", idx, c), din_ready[idx], 0);
    chk($sformatf("u%0d c%0d done", idx, c), done[idx], 0);
  endtask

  task automatic chk_done(input int idx, input string tag);
    chk({tag, " done"}, done[idx], 1);
    chk({tag, " done din_ready"}, din_ready[idx], 1);
    chk({tag, " done sout_valid"}, sout_valid[idx], 0);
    chk({tag, " done busy"}, busy[idx], 0);
  endtask

  // seq lists the expected bits in transmit order, leftmost bit first.
  task automatic run_word(input int idx, input logic [7:0] word, input logic [7:0] seq,
                          input int div, input string tag);
    din_valid[idx] = 1'b1;
    din[idx]       = word;
    @(negedge clk);
    chk({tag, " accept din_ready"}, din_ready[idx], 1);
    chk({tag, " accept sout_valid"}, sout_valid[idx], 0);
    cyc();
    din_valid[idx] = 1'b0;
    din[idx]       = ~word;
    for (int c = 1; c <= 8 * div; c++) begin
      @(negedge clk);
      chk_bit(idx, c, seq[7 - (c - 1) / div]);
      cyc();
    end
    @(negedge clk);
    chk_done(idx, tag);
    cyc();
    @(negedge clk);
    chk({tag, " done one cycle"}, done[idx], 0);
    cyc();
  endtask

  initial begin
    cl        = '0;
    din_valid = '0;
    for (int i = 0; i < 3; i++) din[i] = 8'h00;

    // async reset, before any clock edge
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst u%0d din_ready", i), din_ready[i], 1);
      chk($sformatf("rst u%0d sout_valid", i), sout_valid[i], 0);
      chk($sformatf("rst u%0d sout", i), sout[i], 0);
      chk($sformatf("rst u%0d busy", i), busy[i], 0);
      chk($sformatf("rst u%0d done", i), done[i], 0);
    end
    cyc(); cyc();
    rst = 1'b0;

    // idle with din_valid low
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("idle c%0d din_ready", c), din_ready[0], 1);
      chk($sformatf("idle c%0d sout_valid", c), sout_valid[0], 0);
      chk($sformatf("idle c%0d sout", c), sout[0], 0);
      cyc();
    end

    // 0xA5 LSB first, MSB first; 0x01 MSB first
    run_word(0, 8'hA5, 8'b10100101, 1, "lsb_a5");
    run_word(1, 8'hA5, 8'b10100101, 1, "msb_a5");
    run_word(1, 8'h01, 8'b00000001, 1, "msb_01");
    // divided rate: twelve 1s then twelve 0s
    run_word(2, 8'h0F, 8'b11110000, 3, "div3_0f");

    // back-to-back: din_valid held, second word taken in the done cycle
    din_valid[0] = 1'b1;
    din[0]       = 8'h3C;
    @(negedge clk);
    chk("b2b accept1", din_ready[0], 1);
    cyc();
    din[0] = 8'hC3;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk_bit(0, c, 8'b00111100 >> (8 - c));
      cyc();
    end
    @(negedge clk);
    chk_done(0, "b2b w1");
    cyc();
    din_valid[0] = 1'b0;
    for (int c = 10; c <= 17; c++) begin
      @(negedge clk);
      chk_bit(0, c, 8'b11000011 >> (17 - c));
      cyc();
    end
    @(negedge clk);
    chk_done(0, "b2b w2");
    cyc();

    // clear during bit 3 of 0xFF with a competing handshake
    din_valid[0] = 1'b1;
    din[0]       = 8'hFF;
    cyc();
    din_valid[0] = 1'b0;
    cyc(); cyc(); cyc();
    cl[0]        = 1'b1;
    din_valid[0] = 1'b1;
    din[0]       = 8'h00;
    @(negedge clk);
    chk("cl bit3 sout", sout[0], 1);
    chk("cl bit3 sout_valid", sout_valid[0], 1);
    cyc();
    cl[0]        = 1'b0;
    din_valid[0] = 1'b0;
    @(negedge clk);
    chk("cl after sout_valid", sout_valid[0], 0);
    chk("cl after din_ready", din_ready[0], 1);
    chk("cl after busy", busy[0], 0);
    chk("cl after done", done[0], 0);
    for (int c = 0; c < 8; c++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("cl quiet c%0d done", c), done[0], 0);
      chk($sformatf("cl quiet c%0d sout_valid", c), sout_valid[0], 0);
    end
    cyc();

    // async reset mid-word on the divided instance
    din_valid[2] = 1'b1;
    din[2]       = 8'hFF;
    cyc();
    din_valid[2] = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    #2;
    chk("arst pre sout_valid", sout_valid[2], 1);
    rst = 1'b1;
    #1;
    chk("arst sout_valid", sout_valid[2], 0);
    chk("arst busy", busy[2], 0);
    chk("arst din_ready", din_ready[2], 1);
    chk("arst sout", sout[2], 0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk($sformatf("arst quiet c%0d done", c), done[2], 0);
      chk($sformatf("arst quiet c%0d sout_valid", c), sout_valid[2], 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
